// File: rtl/pc_unit.sv
// Program-counter unit for the multi-cycle MIPS datapath.
// Selects and registers the next PC, and traps exceptions and misaligned targets to a vector.
module pc_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int unsigned       STEP         = 4,
  parameter int unsigned       ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic [2:0]       pc_src,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             exc_req,
  input  logic [1:0]       exc_code,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic [WIDTH-1:0] epc,
  output logic [2:0]       cause,
  output logic             in_trap,
  output logic             illegal_src,
  output logic [7:0]       trap_count
);

  localparam logic [2:0] SRC_SEQ    = 3'd0;
  localparam logic [2:0] SRC_BRANCH = 3'd1;
  localparam logic [2:0] SRC_JUMP   = 3'd2;
  localparam logic [2:0] SRC_REG    = 3'd3;
  localparam logic [2:0] SRC_EPC    = 3'd4;

  // A zero ALIGN_BITS yields an all-zero mask, which disables the check.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'(1) << ALIGN_BITS) - 64'(1));

  typedef enum logic {RUN, TRAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] next_pc;
  logic             src_valid;
  logic             misaligned;

  assign pc_plus_step = pc + WIDTH'(STEP);

  // Next-PC source mux
  always_comb begin
    next_pc = pc;
    case (pc_src)
      SRC_SEQ:    next_pc = pc_plus_step;
      SRC_BRANCH: next_pc = branch_target;
      SRC_JUMP:   next_pc = jump_target;
      SRC_REG:    next_pc = reg_target;
      SRC_EPC:    next_pc = epc;
      default:    next_pc = pc;
    endcase
  end

  assign src_valid  = pc_write && (pc_src <= SRC_EPC);
  assign misaligned = src_valid && (|(next_pc & ALIGN_MASK));

  // RUN/TRAP control with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_VECTOR;
      epc         <= '0;
      cause       <= 3'b000;
      in_trap     <= 1'b0;
      illegal_src <= 1'b0;
      trap_count  <= 8'd0;
    end else begin
      illegal_src <= 1'b0;
      in_trap     <= 1'b0;
      case (state)
        RUN: begin
          if (exc_req || misaligned) begin
            // External requests outrank misalignment; epc keeps the faulting PC.
            pc         <= EXC_VECTOR;
            epc        <= pc;
            cause      <= exc_req ? {1'b0, exc_code} : 3'b100;
            trap_count <= (trap_count == 8'hFF) ? trap_count : trap_count + 8'd1;
            in_trap    <= 1'b1;
            state      <= TRAP;
          end else if (src_valid) begin
            pc <= next_pc;
          end else if (pc_write) begin
            illegal_src <= 1'b1;
          end
        end
        default: begin
          // Handler fetch cycle: all requests are dropped and pc holds the vector.
          state <= RUN;
        end
      endcase
    end
  end

endmodule
